// File: rtl/rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rx_pkg
//  Purpose  : Shared types and default sizes for the nibble-stream
//             deserializer (FSM state encoding, default word/buffer sizes).
//  Revision : 1.0 - initial release
// ============================================================================
package rx_pkg;

  // Receive FSM state encoding (explicit 2-bit width).
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    PUSH = 2'd2
  } rx_state_t;

  localparam int RX_WORD_NIBBLES_DEF = 4;
  localparam int RX_FIFO_DEPTH_DEF   = 4;

endpackage : rx_pkg
`default_nettype wire

// File: rtl/rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : rx_fifo
//  Purpose  : Synchronous word FIFO. A write is accepted when the buffer is
//             not full, or when it is full but a read happens in the same
//             cycle (the slot being freed is reused). rd_data always shows
//             the head entry; storage is cleared by reset so rd_data reads 0.
//  Ports    : Clk      - clock (rising edge)
//             Reset    - asynchronous active-low reset
//             wr_en    - write request
//             wr_data  - word to write
//             rd_en    - pop the head entry (ignored when empty)
//             rd_data  - head entry
//             full     - DEPTH entries held
//             empty    - no entries held
//  Revision : 1.0 - initial release
// ============================================================================
module rx_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_wr;
  logic             do_rd;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_data;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule : rx_fifo
`default_nettype wire

// File: rtl/rx_deserializer.sv
`default_nettype none
// ============================================================================
//  Module   : rx_deserializer
//  Purpose  : Assembles WORD_NIBBLES nibbles (MS nibble first), each qualified
//             by a rising edge of ClkTx while DOutValid is high, into a word
//             and queues it in a FIFO_DEPTH-deep buffer with a valid/ready
//             consumer interface. A frame that loses DOutValid part-way is
//             aborted with a one-cycle FrameErr pulse. Words arriving with the
//             buffer full are dropped and flagged by the sticky Overflow.
//  Config   : `define RX_STATS_EN to implement WordCnt/DropCnt; otherwise
//             both ports read 0 and the counters are not built.
//  Ports    : Clk       - clock (rising edge)
//             Reset     - asynchronous active-low reset (release synchronised)
//             ClkTx     - upstream transmit strobe, synchronous to Clk
//             DOutValid - upstream frame valid
//             DataOut   - upstream nibble
//             RxData    - head-of-buffer word
//             RxValid   - RxData valid
//             RxReady   - consumer accepts RxData
//             FrameErr  - one-cycle pulse on an aborted frame
//             Overflow  - sticky: a word was dropped (buffer full)
//             ClrErr    - synchronous clear of Overflow (a drop wins)
//             WordCnt   - words accepted into the buffer (wraps)
//             DropCnt   - words dropped (wraps)
//  Revision : 1.0 - initial release
// ============================================================================
module rx_deserializer
  import rx_pkg::*;
#(
  parameter int WORD_NIBBLES = RX_WORD_NIBBLES_DEF,
  parameter int FIFO_DEPTH   = RX_FIFO_DEPTH_DEF
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      ClkTx,
  input  logic                      DOutValid,
  input  logic [3:0]                DataOut,
  output logic [4*WORD_NIBBLES-1:0] RxData,
  output logic                      RxValid,
  input  logic                      RxReady,
  output logic                      FrameErr,
  output logic                      Overflow,
  input  logic                      ClrErr,
  output logic [7:0]                WordCnt,
  output logic [7:0]                DropCnt
);

  localparam int W     = 4 * WORD_NIBBLES;
  localparam int CNT_W = $clog2(WORD_NIBBLES + 1);

  // --------------------------------------------------------------------------
  // Reset synchroniser: assertion is immediate, release waits two edges.
  // --------------------------------------------------------------------------
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n;

  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_n      = rst_sync_q[1];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) rst_sync_q <= '0;
    else        rst_sync_q <= rst_sync_d;
  end

  // --------------------------------------------------------------------------
  // Strobe detection
  // --------------------------------------------------------------------------
  logic clktx_q, clktx_d;
  logic strobe;

  assign clktx_d = ClkTx;
  assign strobe  = ClkTx & ~clktx_q;

  // --------------------------------------------------------------------------
  // FSM: state register / next state / output decode
  // --------------------------------------------------------------------------
  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] nib_cnt_q, nib_cnt_d;
  logic             last_nib;
  logic             capture;
  logic             abort;
  logic             push;

  assign last_nib = (nib_cnt_q == CNT_W'(WORD_NIBBLES - 1));

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (strobe && DOutValid) begin
          state_d = (WORD_NIBBLES == 1) ? PUSH : RECV;
        end
      end
      RECV: begin
        // Losing DOutValid mid-frame aborts regardless of the strobe.
        if (!DOutValid)                state_d = IDLE;
        else if (strobe && last_nib)   state_d = PUSH;
      end
      PUSH:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    capture = 1'b0;
    abort   = 1'b0;
    push    = 1'b0;
    case (state_q)
      IDLE:    capture = strobe & DOutValid;
      RECV: begin
        abort   = ~DOutValid;
        capture = strobe & DOutValid;
      end
      PUSH:    push = 1'b1;
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Shift register and nibble counter
  // --------------------------------------------------------------------------
  logic [W-1:0] shreg_q, shreg_d;
  logic         frame_err_q, frame_err_d;

  always_comb begin
    shreg_d     = shreg_q;
    nib_cnt_d   = nib_cnt_q;
    frame_err_d = abort;
    if (abort || push) begin
      nib_cnt_d = '0;
      if (abort) shreg_d = '0;
    end else if (capture) begin
      // Shift left by one nibble; works for any W including a single nibble.
      shreg_d   = (shreg_q << 4) | W'(DataOut);
      nib_cnt_d = (state_q == IDLE) ? CNT_W'(1) : nib_cnt_q + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Word buffer
  // --------------------------------------------------------------------------
  logic fifo_full;
  logic fifo_empty;
  logic rd_en;
  logic drop;

  assign rd_en = ~fifo_empty & RxReady;
  // A full buffer still accepts the word if the head leaves this cycle.
  assign drop  = push & fifo_full & ~rd_en;

  rx_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clk     (Clk),
    .Reset   (rst_n),
    .wr_en   (push),
    .wr_data (shreg_q),
    .rd_en   (rd_en),
    .rd_data (RxData),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign RxValid = ~fifo_empty;

  // --------------------------------------------------------------------------
  // Overflow flag: a drop in the same cycle as ClrErr leaves it set.
  // --------------------------------------------------------------------------
  logic overflow_q, overflow_d;

  always_comb begin
    overflow_d = overflow_q;
    if (ClrErr) overflow_d = 1'b0;
    if (drop)   overflow_d = 1'b1;
  end

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      clktx_q     <= 1'b0;
      nib_cnt_q   <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      clktx_q     <= clktx_d;
      nib_cnt_q   <= nib_cnt_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  assign FrameErr = frame_err_q;
  assign Overflow = overflow_q;

  // --------------------------------------------------------------------------
  // Statistics counters (8-bit, wrapping)
  // --------------------------------------------------------------------------
`ifdef RX_STATS_EN
  logic [7:0] word_cnt_q, word_cnt_d;
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic       wr_ok;

  assign wr_ok      = push & ~drop;
  assign word_cnt_d = word_cnt_q + {7'd0, wr_ok};
  assign drop_cnt_d = drop_cnt_q + {7'd0, drop};

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign WordCnt = word_cnt_q;
  assign DropCnt = drop_cnt_q;
`else
  assign WordCnt = 8'd0;
  assign DropCnt = 8'd0;
`endif

endmodule : rx_deserializer
`default_nettype wire

// File: tb/tb_rx_deserializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rx_deserializer
//  Purpose  : Directed self-checking bench for rx_deserializer (default
//             parameters: 16-bit words, 4-deep buffer). Expected counter
//             values follow whether RX_STATS_EN is defined for the build.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rx_deserializer;

`ifdef RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        Clk;
  logic        Reset;
  logic        ClkTx;
  logic        DOutValid;
  logic [3:0]  DataOut;
  logic [15:0] RxData;
  logic        RxValid;
  logic        RxReady;
  logic        FrameErr;
  logic        Overflow;
  logic        ClrErr;
  logic [7:0]  WordCnt;
  logic [7:0]  DropCnt;

  int errors = 0;
  int checks = 0;

  rx_deserializer dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .ClkTx     (ClkTx),
    .DOutValid (DOutValid),
    .DataOut   (DataOut),
    .RxData    (RxData),
    .RxValid   (RxValid),
    .RxReady   (RxReady),
    .FrameErr  (FrameErr),
    .Overflow  (Overflow),
    .ClrErr    (ClrErr),
    .WordCnt   (WordCnt),
    .DropCnt   (DropCnt)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic logic [7:0] cnt_exp(input int n);
    return STATS ? 8'(n) : 8'd0;
  endfunction

  // One strobed nibble: ClkTx high for one cycle, then low for one cycle.
  task automatic send_nibble(input logic [3:0] n);
    ClkTx = 1'b1; DOutValid = 1'b1; DataOut = n;
    @(negedge Clk);
    ClkTx = 1'b0;
    @(negedge Clk);
  endtask

  // Full frame; optionally pulse ClrErr and/or RxReady during the PUSH cycle.
  task automatic send_frame(input logic [15:0] w, input bit clr, input bit rdy);
    for (int i = 3; i >= 1; i--) send_nibble(w[4*i +: 4]);
    ClkTx = 1'b1; DOutValid = 1'b1; DataOut = w[3:0];
    @(negedge Clk);
    ClkTx = 1'b0;
    if (clr) ClrErr = 1'b1;
    if (rdy) RxReady = 1'b1;
    @(negedge Clk);
    if (clr) ClrErr = 1'b0;
    if (rdy) RxReady = 1'b0;
    DOutValid = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge Clk);
    checks++; if (RxValid !== 1'b0) begin errors++; $display("FAIL reset_rxvalid got=%0h exp=0", RxValid); end
    checks++; if (RxData !== 16'h0) begin errors++; $display("FAIL reset_rxdata got=%0h exp=0", RxData); end
    checks++; if (FrameErr !== 1'b0) begin errors++; $display("FAIL reset_frameerr got=%0h exp=0", FrameErr); end
    checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%0h exp=0", Overflow); end
    checks++; if (WordCnt !== 8'd0 || DropCnt !== 8'd0) begin errors++; $display("FAIL reset_counts got=%0h/%0h exp=0/0", WordCnt, DropCnt); end
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
  endtask

  task automatic test_single;
    RxReady = 1'b1;
    send_nibble(4'hA);
    send_nibble(4'hB);
    send_nibble(4'h5);
    ClkTx = 1'b1; DOutValid = 1'b1; DataOut = 4'h4;
    @(negedge Clk);
    ClkTx = 1'b0;
    checks++; if (RxValid !== 1'b0) begin errors++; $display("FAIL single_no_bypass got=%0h exp=0", RxValid); end
    @(negedge Clk);
    DOutValid = 1'b0;
    checks++; if (RxValid !== 1'b1) begin errors++; $display("FAIL single_valid_n2 got=%0h exp=1", RxValid); end
    checks++; if (RxData !== 16'hAB54) begin errors++; $display("FAIL single_data got=%0h exp=ab54", RxData); end
    @(negedge Clk);
    checks++; if (RxValid !== 1'b0) begin errors++; $display("FAIL single_consumed got=%0h exp=0", RxValid); end
    checks++; if (WordCnt !== cnt_exp(1)) begin errors++; $display("FAIL single_wordcnt got=%0d exp=%0d", WordCnt, cnt_exp(1)); end
  endtask

  task automatic test_abort;
    RxReady = 1'b1;
    send_nibble(4'h9);
    send_nibble(4'h8);
    checks++; if (FrameErr !== 1'b0) begin errors++; $display("FAIL abort_pre got=%0h exp=0", FrameErr); end
    DOutValid = 1'b0;
    @(negedge Clk);
    checks++; if (FrameErr !== 1'b1) begin errors++; $display("FAIL abort_pulse got=%0h exp=1", FrameErr); end
    @(negedge Clk);
    checks++; if (FrameErr !== 1'b0) begin errors++; $display("FAIL abort_pulse_end got=%0h exp=0", FrameErr); end
    checks++; if (RxValid !== 1'b0) begin errors++; $display("FAIL abort_nowrite got=%0h exp=0", RxValid); end
    send_frame(16'h1234, 1'b0, 1'b0);
    checks++; if (RxValid !== 1'b1 || RxData !== 16'h1234) begin errors++; $display("FAIL abort_next_frame got=%0h/%0h exp=1/1234", RxValid, RxData); end
    @(negedge Clk);
    checks++; if (RxValid !== 1'b0) begin errors++; $display("FAIL abort_next_consumed got=%0h exp=0", RxValid); end
    checks++; if (WordCnt !== cnt_exp(2)) begin errors++; $display("FAIL abort_wordcnt got=%0d exp=%0d", WordCnt, cnt_exp(2)); end
  endtask

  task automatic test_overflow;
    logic [15:0] words [5];
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
    words[3] = 16'h4444; words[4] = 16'h5555;
    RxReady = 1'b0;
    for (int i = 0; i < 5; i++) send_frame(words[i], 1'b0, 1'b0);
    checks++; if (RxValid !== 1'b1 || RxData !== 16'h1111) begin errors++; $display("FAIL ovf_head got=%0h/%0h exp=1/1111", RxValid, RxData); end
    checks++; if (Overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%0h exp=1", Overflow); end
    checks++; if (DropCnt !== cnt_exp(1)) begin errors++; $display("FAIL ovf_dropcnt got=%0d exp=%0d", DropCnt, cnt_exp(1)); end
    checks++; if (WordCnt !== cnt_exp(6)) begin errors++; $display("FAIL ovf_wordcnt got=%0d exp=%0d", WordCnt, cnt_exp(6)); end
    ClrErr = 1'b1;
    @(negedge Clk);
    ClrErr = 1'b0;
    checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%0h exp=0", Overflow); end
    // Another drop with ClrErr in the same cycle: the set must win.
    send_frame(16'h6666, 1'b1, 1'b0);
    checks++; if (Overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got=%0h exp=1", Overflow); end
    checks++; if (DropCnt !== cnt_exp(2)) begin errors++; $display("FAIL ovf_dropcnt2 got=%0d exp=%0d", DropCnt, cnt_exp(2)); end
    RxReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (RxValid !== 1'b1 || RxData !== words[i]) begin
        errors++; $display("FAIL ovf_drain%0d got=%0h/%0h exp=1/%0h", i, RxValid, RxData, words[i]);
      end
      @(negedge Clk);
    end
    checks++; if (RxValid !== 1'b0) begin errors++; $display("FAIL ovf_drained got=%0h exp=0", RxValid); end
    RxReady = 1'b0;
  endtask

  task automatic test_full_read;
    logic [15:0] words [4];
    words[0] = 16'hA002; words[1] = 16'hA003; words[2] = 16'hA004; words[3] = 16'hA005;
    RxReady = 1'b0;
    ClrErr = 1'b1;
    @(negedge Clk);
    ClrErr = 1'b0;
    send_frame(16'hA001, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_frame(words[i], 1'b0, 1'b0);
    // Buffer full; the fifth word arrives while the head is being read.
    send_frame(16'hA005, 1'b0, 1'b1);
    checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL fullrd_overflow got=%0h exp=0", Overflow); end
    checks++; if (DropCnt !== cnt_exp(2)) begin errors++; $display("FAIL fullrd_dropcnt got=%0d exp=%0d", DropCnt, cnt_exp(2)); end
    checks++; if (WordCnt !== cnt_exp(11)) begin errors++; $display("FAIL fullrd_wordcnt got=%0d exp=%0d", WordCnt, cnt_exp(11)); end
    RxReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (RxValid !== 1'b1 || RxData !== words[i]) begin
        errors++; $display("FAIL fullrd_drain%0d got=%0h/%0h exp=1/%0h", i, RxValid, RxData, words[i]);
      end
      @(negedge Clk);
    end
    checks++; if (RxValid !== 1'b0) begin errors++; $display("FAIL fullrd_drained got=%0h exp=0", RxValid); end
    RxReady = 1'b0;
  endtask

  task automatic test_reset_midframe;
    RxReady = 1'b0;
    send_frame(16'hBEEF, 1'b0, 1'b0);
    checks++; if (RxValid !== 1'b1) begin errors++; $display("FAIL rstmid_buffered got=%0h exp=1", RxValid); end
    send_nibble(4'h1);
    send_nibble(4'h2);
    send_nibble(4'h3);
    #2 Reset = 1'b0;
    #1;
    checks++; if (RxValid !== 1'b0 || RxData !== 16'h0) begin errors++; $display("FAIL rstmid_async_rx got=%0h/%0h exp=0/0", RxValid, RxData); end
    checks++; if (WordCnt !== 8'd0 || DropCnt !== 8'd0 || Overflow !== 1'b0) begin errors++; $display("FAIL rstmid_async_stats got=%0h/%0h/%0h exp=0/0/0", WordCnt, DropCnt, Overflow); end
    @(negedge Clk);
    checks++; if (FrameErr !== 1'b0) begin errors++; $display("FAIL rstmid_no_frameerr got=%0h exp=0", FrameErr); end
    DOutValid = 1'b0;
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    checks++; if (FrameErr !== 1'b0 || RxValid !== 1'b0) begin errors++; $display("FAIL rstmid_release got=%0h/%0h exp=0/0", FrameErr, RxValid); end
    RxReady = 1'b1;
    send_frame(16'hFFC0, 1'b0, 1'b0);
    checks++; if (RxValid !== 1'b1 || RxData !== 16'hFFC0) begin errors++; $display("FAIL rstmid_frame got=%0h/%0h exp=1/ffc0", RxValid, RxData); end
    @(negedge Clk);
    checks++; if (WordCnt !== cnt_exp(1)) begin errors++; $display("FAIL rstmid_wordcnt got=%0d exp=%0d", WordCnt, cnt_exp(1)); end
  endtask

  initial begin
    Reset     = 1'b0;
    ClkTx     = 1'b0;
    DOutValid = 1'b0;
    DataOut   = 4'h0;
    RxReady   = 1'b0;
    ClrErr    = 1'b0;
    test_reset();
    test_single();
    test_abort();
    test_overflow();
    test_full_read();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_rx_deserializer
`default_nettype wire
